// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: one LSTM timestep over NX x-beats and NH h-beats.
// Four gate accumulators are fed by a valid/ready operand stream. The cell
// state is kept in o_c between timesteps. The results a, i, f, o, c and h
// are announced with a single-cycle o_valid pulse.
module lstm_cell_seq #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int NX    = 4,
   parameter int NH    = 4,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_clr_state,
   input  logic [WIDTH-1:0] i_b_a,
   input  logic [WIDTH-1:0] i_b_i,
   input  logic [WIDTH-1:0] i_b_f,
   input  logic [WIDTH-1:0] i_b_o,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_d,
   input  logic [WIDTH-1:0] i_w_a,
   input  logic [WIDTH-1:0] i_w_i,
   input  logic [WIDTH-1:0] i_w_f,
   input  logic [WIDTH-1:0] i_w_o,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_i,
   output logic [WIDTH-1:0] o_f,
   output logic [WIDTH-1:0] o_o,
   output logic [WIDTH-1:0] o_c,
   output logic [WIDTH-1:0] o_h,
   output logic             o_valid,
   output logic             o_busy
);
   localparam int NMAX = (NX > NH) ? NX : NH;
   localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

   localparam logic signed [2*WIDTH-1:0] MAX_2W = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] MIN_2W = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0]   MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0]   MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]          FOUR   = WIDTH'(4) << FRAC;
   localparam logic [WIDTH-1:0]          QMASK  = (WIDTH'(1) << (FRAC-2)) - WIDTH'(1);
   localparam logic signed [WIDTH-1:0]   HALF   = WIDTH'(1) << (FRAC-1);

   typedef enum logic [2:0] {S_IDLE, S_ACC_X, S_ACC_H, S_ACT, S_UPD} state_t;

   state_t                  state_reg;
   logic [CW-1:0]           cnt_reg;
   logic                    clr_reg;
   logic                    beat;
   logic [3:0][WIDTH-1:0]   acc_q;
   logic [3:0][WIDTH-1:0]   bias_v;
   logic [3:0][WIDTH-1:0]   w_v;
   logic signed [WIDTH-1:0] c_prev;
   logic signed [WIDTH-1:0] c_new;

   // Reduce a double-width value to WIDTH bits: clamp or wrap.
   function automatic logic signed [WIDTH-1:0] fx_reduce(input logic signed [2*WIDTH-1:0] v);
      if (SAT != 0 && v > MAX_2W) return MAX_W;
      if (SAT != 0 && v < MIN_2W) return MIN_W;
      return $signed(v[WIDTH-1:0]);
   endfunction

   function automatic logic signed [WIDTH-1:0] fx_add(input logic signed [WIDTH-1:0] p,
                                                      input logic signed [WIDTH-1:0] q);
      logic signed [2*WIDTH-1:0] s;
      s = {{WIDTH{p[WIDTH-1]}}, p} + {{WIDTH{q[WIDTH-1]}}, q};
      return fx_reduce(s);
   endfunction

   // Full signed product, floor shift by FRAC, then reduce.
   function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] p,
                                                      input logic signed [WIDTH-1:0] q);
      logic signed [2*WIDTH-1:0] prod;
      prod = {{WIDTH{p[WIDTH-1]}}, p} * {{WIDTH{q[WIDTH-1]}}, q};
      prod = prod >>> FRAC;
      return fx_reduce(prod);
   endfunction

   // tanh(k/4) for k = 0..16 in Q.24.
   function automatic logic [24:0] tanh_lut(input logic [4:0] k);
      case (k)
         5'd0:    return 25'd0;
         5'd1:    return 25'd4109053;
         5'd2:    return 25'd7753040;
         5'd3:    return 25'd10656031;
         5'd4:    return 25'd12777430;
         5'd5:    return 25'd14231838;
         5'd6:    return 25'd15185868;
         5'd7:    return 25'd15793661;
         5'd8:    return 25'd16173699;
         5'd9:    return 25'd16408555;
         5'd10:   return 25'd16552642;
         5'd11:   return 25'd16640645;
         5'd12:   return 25'd16694248;
         5'd13:   return 25'd16726787;
         5'd14:   return 25'd16746646;
         5'd15:   return 25'd16758668;
         default: return 25'd16765964;
      endcase
   endfunction

   // Odd-symmetric piecewise-linear tanh. The segments are 0.25 wide.
   // The output is flat at tanh(4) for |x| >= 4.
   function automatic logic signed [WIDTH-1:0] fx_tanh(input logic signed [WIDTH-1:0] x);
      logic [WIDTH-1:0] ax;
      logic [3:0]       idx;
      logic [24:0]      lo;
      logic [24:0]      hi;
      logic [63:0]      fr;
      logic [63:0]      y;
      logic [WIDTH-1:0] mag;
      ax  = x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
      idx = 4'(ax >> (FRAC-2));
      lo  = tanh_lut({1'b0, idx});
      hi  = tanh_lut({1'b0, idx} + 5'd1);
      fr  = 64'(ax & QMASK);
      if (ax >= FOUR)
         y = 64'(tanh_lut(5'd16));
      else
         y = 64'(lo) + ((64'(hi - lo) * fr) >> (FRAC-2));
      y   = (y << FRAC) >> 24;
      mag = WIDTH'(y);
      return x[WIDTH-1] ? -$signed(mag) : $signed(mag);
   endfunction

   // sigmoid(x) = 0.5 + tanh(x/2)/2
   function automatic logic signed [WIDTH-1:0] fx_sigmoid(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] t;
      t = fx_tanh(x >>> 1);
      return (t >>> 1) + HALF;
   endfunction

   assign o_ready = (state_reg == S_ACC_X) || (state_reg == S_ACC_H);
   assign o_busy  = (state_reg != S_IDLE);
   assign beat    = i_valid && o_ready;
   assign bias_v  = {i_b_o, i_b_f, i_b_i, i_b_a};
   assign w_v     = {i_w_o, i_w_f, i_w_i, i_w_a};

   // Compute the cell-state update from the registered activations.
   always_comb begin
      c_prev = clr_reg ? '0 : $signed(o_c);
      c_new  = fx_add(fx_mul($signed(o_a), $signed(o_i)), fx_mul($signed(o_f), c_prev));
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_gate
         logic signed [WIDTH-1:0] acc_reg;
         // Per-gate accumulator: load bias on start, MAC on each accepted beat.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               acc_reg <= '0;
            else if (state_reg == S_IDLE && i_start)
               acc_reg <= $signed(bias_v[gi]);
            else if (beat)
               acc_reg <= fx_add(acc_reg, fx_mul($signed(i_d), $signed(w_v[gi])));
         end
         assign acc_q[gi] = acc_reg;
      end
   endgenerate

   // Sequencer: the beat counting, the activation and update stages, and the output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         clr_reg   <= 1'b0;
         o_a       <= '0;
         o_i       <= '0;
         o_f       <= '0;
         o_o       <= '0;
         o_c       <= '0;
         o_h       <= '0;
         o_valid   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (i_start) begin
                  state_reg <= S_ACC_X;
                  cnt_reg   <= '0;
                  clr_reg   <= i_clr_state;
               end
            end
            S_ACC_X: begin
               if (i_valid) begin
                  if (cnt_reg == CW'(NX-1)) begin
                     state_reg <= S_ACC_H;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            S_ACC_H: begin
               if (i_valid) begin
                  if (cnt_reg == CW'(NH-1)) begin
                     state_reg <= S_ACT;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            S_ACT: begin
               o_a       <= fx_tanh($signed(acc_q[0]));
               o_i       <= fx_sigmoid($signed(acc_q[1]));
               o_f       <= fx_sigmoid($signed(acc_q[2]));
               o_o       <= fx_sigmoid($signed(acc_q[3]));
               state_reg <= S_UPD;
            end
            S_UPD: begin
               o_c       <= c_new;
               o_h       <= fx_mul(fx_tanh(c_new), $signed(o_o));
               o_valid   <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed testbench for lstm_cell_seq. It runs two instances on the same stimulus.
// u_dut saturates. u_wrap wraps.
module tb_lstm_cell_seq;
   localparam int W = 32;
   localparam logic signed [W-1:0] ONE  = 32'sh0100_0000;
   localparam logic signed [W-1:0] HALF = 32'sh0080_0000;
   localparam int TOL7 = 131072;   // 2^-7
   localparam int TOL8 = 65536;    // 2^-8

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_start = 1'b0, i_clr_state = 1'b0, i_valid = 1'b0;
   logic [W-1:0] i_b_a = '0, i_b_i = '0, i_b_f = '0, i_b_o = '0;
   logic [W-1:0] i_d = '0, i_w_a = '0, i_w_i = '0, i_w_f = '0, i_w_o = '0;
   logic [W-1:0] o_a, o_i, o_f, o_o, o_c, o_h;
   logic         o_ready, o_valid, o_busy;
   logic [W-1:0] w_a, w_i, w_f, w_o, w_c, w_h;
   logic         w_ready, w_valid, w_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int accepted;
   int latency;
   logic signed [W-1:0] bd [8];
   logic signed [W-1:0] bwa[8];
   logic signed [W-1:0] bwi[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lstm_cell_seq #(.WIDTH(32), .FRAC(24), .NX(4), .NH(4), .SAT(1)) u_dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_clr_state(i_clr_state),
      .i_b_a(i_b_a), .i_b_i(i_b_i), .i_b_f(i_b_f), .i_b_o(i_b_o),
      .i_valid(i_valid), .o_ready(o_ready), .i_d(i_d),
      .i_w_a(i_w_a), .i_w_i(i_w_i), .i_w_f(i_w_f), .i_w_o(i_w_o),
      .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o), .o_c(o_c), .o_h(o_h),
      .o_valid(o_valid), .o_busy(o_busy));

   lstm_cell_seq #(.WIDTH(32), .FRAC(24), .NX(4), .NH(4), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .i_start(i_start), .i_clr_state(i_clr_state),
      .i_b_a(i_b_a), .i_b_i(i_b_i), .i_b_f(i_b_f), .i_b_o(i_b_o),
      .i_valid(i_valid), .o_ready(w_ready), .i_d(i_d),
      .i_w_a(i_w_a), .i_w_i(i_w_i), .i_w_f(i_w_f), .i_w_o(i_w_o),
      .o_a(w_a), .o_i(w_i), .o_f(w_f), .o_o(w_o), .o_c(w_c), .o_h(w_h),
      .o_valid(w_valid), .o_busy(w_busy));

   task automatic chk(input string tag, input logic signed [W-1:0] obs,
                      input logic signed [W-1:0] exp_v, input int tol);
      longint d;
      n_tests++;
      d = longint'(obs) - longint'(exp_v);
      if (d < 0) d = -d;
      if (d > longint'(tol)) begin
         n_fail++;
         $display("FAIL %s: got %h (%0d) expected %h (%0d) tol %0d",
                  tag, obs, obs, exp_v, exp_v, tol);
      end
   endtask

   task automatic set_beats(input logic signed [W-1:0] d, input logic signed [W-1:0] wa,
                            input logic signed [W-1:0] wi);
      for (int b = 0; b < 8; b++) begin
         bd[b] = d; bwa[b] = wa; bwi[b] = wi;
      end
   endtask

   // One timestep: start, nbeats operand beats with optional random gaps, then wait for o_valid.
   task automatic run_step(input string name, input logic signed [W-1:0] ba, input logic signed [W-1:0] bi,
                           input logic signed [W-1:0] bf, input logic signed [W-1:0] bo,
                           input logic clr, input int max_gap, input int nbeats);
      int  t0;
      int  gap;
      logic rdy;
      @(negedge clk);
      i_b_a = ba; i_b_i = bi; i_b_f = bf; i_b_o = bo;
      i_clr_state = clr; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      t0 = cyc;
      accepted = 0;
      latency = -1;
      for (int b = 0; b < nbeats; b++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         i_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            i_d = $urandom; i_w_a = $urandom; i_w_i = $urandom;
            @(negedge clk);
         end
         i_valid = 1'b1;
         i_d = bd[b]; i_w_a = bwa[b]; i_w_i = bwi[b]; i_w_f = '0; i_w_o = '0;
         for (int t = 0; t < 20; t++) begin
            rdy = o_ready;
            @(negedge clk);
            if (rdy) begin
               accepted++;
               break;
            end
         end
      end
      i_valid = 1'b0;
      i_d = $urandom; i_w_a = $urandom; i_w_i = $urandom;
      if (nbeats < 8) return;
      chk({name, "_ready_low"}, W'(o_ready), 0, 0);
      for (int t = 0; t < 30; t++) begin
         if (o_valid) begin
            latency = cyc - t0;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_beats"}, accepted, 8, 0);
      chk({name, "_valid_seen"}, W'(latency >= 0), 1, 0);
      @(negedge clk);
      chk({name, "_valid_pulse"}, W'(o_valid), 0, 0);
      $display("[TB] %s: a=%h i=%h f=%h o=%h c=%h h=%h beats=%0d lat=%0d",
               name, o_a, o_i, o_f, o_o, o_c, o_h, accepted, latency);
   endtask

   task automatic zero_test(input string name);
      set_beats('0, '0, '0);
      run_step(name, '0, '0, '0, '0, 1'b1, 0, 8);
      chk({name, "_a"}, o_a, 0, 0);
      chk({name, "_i"}, o_i, HALF, TOL8);
      chk({name, "_f"}, o_f, HALF, TOL8);
      chk({name, "_o"}, o_o, HALF, TOL8);
      chk({name, "_c"}, o_c, 0, 0);
      chk({name, "_h"}, o_h, 0, 0);
      chk({name, "_lat"}, latency, 10, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a", o_a, 0, 0);
      chk("rst_c", o_c, 0, 0);
      chk("rst_h", o_h, 0, 0);
      chk("rst_valid", W'(o_valid), 0, 0);
      chk("rst_busy", W'(o_busy), 0, 0);
      chk("rst_ready", W'(o_ready), 0, 0);
      $display("[TB] reset: a=%h c=%h h=%h busy=%0b ready=%0b", o_a, o_c, o_h, o_busy, o_ready);
      rst = 1'b1;

      zero_test("zero");

      // Write 1.0 into the cell, then hold it, then clear it.
      set_beats('0, '0, '0);
      run_step("write", 32'sh0800_0000, 32'sh0800_0000, -32'sh0800_0000, 32'sh0800_0000, 1'b1, 0, 8);
      chk("write_c", o_c, ONE, TOL7);
      chk("write_h", o_h, 32'sd12777430, TOL7);
      run_step("hold", 32'sh0800_0000, -32'sh0800_0000, 32'sh0800_0000, 32'sh0800_0000, 1'b0, 0, 8);
      chk("hold_c", o_c, ONE, TOL7);
      run_step("clear", 32'sh0800_0000, -32'sh0800_0000, 32'sh0800_0000, 32'sh0800_0000, 1'b1, 0, 8);
      chk("clear_c", o_c, 0, TOL7);

      // Dot product 8 x (0.5 * 1.0) = 4.0, without and then with valid gaps.
      set_beats(HALF, ONE, '0);
      run_step("dot", '0, '0, '0, '0, 1'b1, 0, 8);
      chk("dot_a", o_a, 32'sd16765475, TOL8);
      chk("dot_c", o_c, 32'sd8382738, TOL7);
      chk("dot_lat", latency, 10, 0);
      run_step("dot_gap", '0, '0, '0, '0, 1'b1, 3, 8);
      chk("gap_a", o_a, 32'sd16765475, TOL8);
      chk("gap_c", o_c, 32'sd8382738, TOL7);

      // 100 * 100 saturates the accumulator.
      set_beats('0, '0, '0);
      bd[0] = 32'sh6400_0000; bwa[0] = 32'sh6400_0000;
      run_step("sat", '0, '0, '0, '0, 1'b1, 0, 8);
      chk("sat_a", o_a, ONE, TOL8);

      // 8*16 = 128 and 8*32 = 256. These clamp in u_dut. They wrap to -128 and 0 in u_wrap.
      set_beats('0, '0, '0);
      bd[0] = 32'sh0800_0000; bwa[0] = 32'sh1000_0000; bwi[0] = 32'sh2000_0000;
      run_step("wrap", '0, '0, '0, '0, 1'b1, 0, 8);
      chk("clamp_a", o_a, ONE, TOL8);
      chk("clamp_i", o_i, ONE, TOL8);
      chk("wrap_a", w_a, -ONE, TOL8);
      chk("wrap_i", w_i, HALF, 0);
      $display("[TB] wrap inst: a=%h i=%h c=%h h=%h", w_a, w_i, w_c, w_h);

      // Abort in ACC_H after 6 beats.
      set_beats(HALF, ONE, '0);
      run_step("abort", '0, '0, '0, '0, 1'b1, 0, 6);
      rst = 1'b0;
      #1;
      chk("abort_a", o_a, 0, 0);
      chk("abort_i", o_i, 0, 0);
      chk("abort_c", o_c, 0, 0);
      chk("abort_h", o_h, 0, 0);
      chk("abort_busy", W'(o_busy), 0, 0);
      chk("abort_ready", W'(o_ready), 0, 0);
      chk("abort_valid", W'(o_valid), 0, 0);
      chk("abort_wrap_c", w_c, 0, 0);
      $display("[TB] abort: a=%h c=%h h=%h busy=%0b", o_a, o_c, o_h, o_busy);
      @(negedge clk);
      rst = 1'b1;
      zero_test("rezero");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lstm_cell_seq.md
Name: lstm_cell_seq

Overview:
- Parametrised, self-sequencing successor to the single-beat LSTM cell.
- Computes one LSTM timestep over a vector input of NX elements and a recurrent input of NH elements. Operands arrive one beat per element over a valid/ready stream into four gate MAC accumulators.
- Holds the cell state c(t-1) internally between timesteps and emits a, i, f, o, c, h with a one-cycle o_valid pulse.
- Sits between the layer controller (weight/operand fetch) and the hidden-state buffer.

Parameters:
WIDTH, 32, data word width (signed fixed point)
FRAC, 24, fractional bits
NX, 4, x-vector beats per timestep (>=1)
NH, 4, h-vector beats per timestep (>=1)
SAT, 1, 1 = saturating accumulate/multiply, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
i_start  in  1  begin a timestep; sampled only in IDLE
i_clr_state  in  1  sampled with i_start; 1 = treat c(t-1) as 0
i_b_a, i_b_i, i_b_f, i_b_o  in  WIDTH each  gate biases; loaded into accumulators on accepted start
i_valid  in  1  operand beat valid
o_ready  out  1  high in ACC_X/ACC_H
i_d  in  WIDTH  operand (x element in ACC_X, h element in ACC_H)
i_w_a, i_w_i, i_w_f, i_w_o  in  WIDTH each  weights for this beat (W during ACC_X, U during ACC_H)
o_a, o_i, o_f, o_o  out  WIDTH each  registered activations
o_c  out  WIDTH  cell state register
o_h  out  WIDTH  hidden output register
o_valid  out  1  one-cycle pulse, outputs updated
o_busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all accumulators, o_a..o_o, o_c, o_h = 0; o_valid=0, o_ready=0, o_busy=0.
- FSM: IDLE -> ACC_X -> ACC_H -> ACT -> UPD -> IDLE.
  - IDLE -> ACC_X on i_start=1. Each accumulator acc_g <= i_b_g. Beat counter <= 0. Latch i_clr_state.
  - ACC_X: beat accepted when i_valid && o_ready. On each accepted beat, acc_g <= acc_g + mul(i_d, i_w_g). After the NX-th beat, go to ACC_H and zero the counter.
  - ACC_H: same accumulate rule. After the NH-th beat, go to ACT.
  - ACT (1 cycle): o_a <= tanh(acc_a); o_i, o_f, o_o <= sigmoid(acc_g). Use the codebase's combinational tanh/sigmoid blocks.
  - UPD (1 cycle): c_new = mul(o_a, o_i) + mul(o_f, cprev). cprev = 0 if the latched clr bit is set, else o_c. o_c <= c_new; o_h <= mul(tanh(c_new), o_o); o_valid <= 1 for exactly the following cycle; go to IDLE.
- Latency: last beat accepted at edge k; activations registered at k+1; o_c/o_h/o_valid registered at k+2.
- Minimum timestep: NX+NH+3 cycles, including the start cycle.
- mul(p, q): full 2*WIDTH signed product, arithmetic shift right by FRAC (floor), then reduce to WIDTH.
  - SAT=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=0: truncate.
- Additions (accumulate, c_new): same clamp/wrap rule per SAT.
- Gaps: i_valid low in ACC states stalls with no change. i_d and weights are ignored when no beat is accepted.
- i_start outside IDLE is ignored. i_start in the same cycle o_valid is high is accepted, since the FSM is in IDLE.
- o_c persists across timesteps. It changes only in UPD or on reset.
- o_a..o_o and o_h hold their values until the next ACT/UPD.
- Reset mid-timestep aborts immediately. No partial outputs; o_valid is not asserted.

Test Plan:
- Zero test: all weights and biases 0, i_clr_state=1 -> o_a=0, o_i=o_f=o_o=0x00800000 (0.5, +/-2^-8), o_c=0, o_h=0. o_valid exactly NX+NH+2 cycles after start (NX=NH=4: cycle 10).
- Write then hold:
  - Step 1: weights 0, b_a=b_i=b_o=8.0, b_f=-8.0, clr=1 -> o_c=1.0 +/-2^-7, o_h=0.7616 +/-2^-7.
  - Step 2: clr=0, b_i=-8.0, b_f=8.0 -> o_c stays 1.0 +/-2^-7.
- Clear state: after the write step, start with clr=1, b_i=-8.0, b_f=8.0 -> o_c=0 +/-2^-7.
- Backpressure: same operands as a dot-product case (i_d=0.5, w_a=1.0 on all 8 beats, b_a=0 -> acc_a=4.0, o_a=tanh(4)=0.9993). Insert random i_valid gaps -> identical outputs; exactly 8 accepted beats; o_ready low outside ACC states.
- Saturation: SAT=1, i_d=100.0, w_a=100.0 -> acc_a clamps to 0x7FFFFFFF, o_a=1.0 +/-2^-8. SAT=0 -> product wraps (check bit-exact against model).
- Reset mid ACC_H: assert rst low after 6 beats -> all outputs 0 and o_busy=0 immediately. A fresh timestep afterward matches the zero test exactly.
